// File: rtl/t_ff_bank.sv
// -----------------------------------------------------------------------------
// t_ff_bank
//   Bank of CHANNELS independent toggle flip-flops with a shared toggle divider.
//   Each channel counts its accepted toggle requests. The channel output inverts
//   on every (div_q+1)-th request, so div_q = 0 behaves as a plain T flip-flop.
//   Per channel, clr wins over set, and set wins over toggle. flip marks a change
//   of out, one cycle after out has moved.
//
// Ports
//   clk       : single clock; all state updates on its rising edge
//   rst       : asynchronous active-high reset
//   toggle    : [CHANNELS] per-channel toggle request
//   set       : [CHANNELS] per-channel synchronous force-to-1
//   clr       : [CHANNELS] per-channel synchronous force-to-0
//   freeze    : global hold; toggle requests are ignored and counts are held
//   div_load  : load strobe for the divide register
//   div_in    : [DIV_W] divide value written on div_load
//   out       : [CHANNELS] registered channel state
//   flip      : [CHANNELS] registered one-cycle pulse after a change of out
//   div_q     : [DIV_W] current divide register value
// -----------------------------------------------------------------------------
module t_ff_bank #(
    parameter int                  CHANNELS  = 8,
    parameter int                  DIV_W     = 4,
    parameter logic [CHANNELS-1:0] POR_VALUE = '0,
    parameter logic [DIV_W-1:0]    DIV_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] toggle,
    input  logic [CHANNELS-1:0] set,
    input  logic [CHANNELS-1:0] clr,
    input  logic                freeze,
    input  logic                div_load,
    input  logic [DIV_W-1:0]    div_in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] flip,
    output logic [DIV_W-1:0]    div_q
);

    // Request counters, one per channel. They never exceed div_q.
    logic [DIV_W-1:0]    cnt     [CHANNELS];
    logic [DIV_W-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] out_nxt;
    // Holds the value of out from before the last edge, so that flip can be
    // produced one cycle after out changes.
    logic [CHANNELS-1:0] out_prev_p1;

    // Counter advance. The counter wraps modulo 2^DIV_W, which is only reached
    // when div_q is all-ones.
    function automatic logic [DIV_W-1:0] cnt_inc(input logic [DIV_W-1:0] c);
        return c + DIV_W'(1);
    endfunction

    always_comb begin
        out_nxt = out;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (clr[i]) begin
                out_nxt[i] = 1'b0;
                cnt_nxt[i] = '0;
            end else if (set[i]) begin
                out_nxt[i] = 1'b1;
                cnt_nxt[i] = '0;
            end else if (div_load) begin
                // A divider change restarts every count and drops the requests
                // of this cycle.
                cnt_nxt[i] = '0;
            end else if (toggle[i] && !freeze) begin
                if (cnt[i] == div_q) begin
                    out_nxt[i] = ~out[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt_inc(cnt[i]);
                end
            end
        end
    end

    // ---- stage p0: channel state, counters, divide register ----
    // Reset is the only defined start state, so power-up relies on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= POR_VALUE;
            div_q <= DIV_RESET;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            out <= out_nxt;
            if (div_load) begin
                div_q <= div_in;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // ---- stage p1: change detect -> flip pulse ----
    // out_prev_p1 resets to POR_VALUE, matching out, so reset never pulses flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_prev_p1 <= POR_VALUE;
            flip        <= '0;
        end else begin
            out_prev_p1 <= out;
            flip        <= out ^ out_prev_p1;
        end
    end

endmodule

// File: tb/tb_t_ff_bank.sv
module tb_t_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] toggle = '0;
    logic [7:0] set = '0;
    logic [7:0] clr = '0;
    logic       freeze = 1'b0;
    logic       div_load = 1'b0;
    logic [3:0] div_in = '0;
    logic [7:0] out;
    logic [7:0] flip;
    logic [3:0] div_q;

    int checks = 0;
    int fails  = 0;

    t_ff_bank #(
        .CHANNELS (8),
        .DIV_W    (4),
        .POR_VALUE(8'h0F),
        .DIV_RESET(4'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .toggle  (toggle),
        .set     (set),
        .clr     (clr),
        .freeze  (freeze),
        .div_load(div_load),
        .div_in  (div_in),
        .out     (out),
        .flip    (flip),
        .div_q   (div_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_out033  [6] = '{8'h0F, 8'h0F, 8'h0D, 8'h0D, 8'h0D, 8'h0F};
    logic [7:0] exp_flip033 [6] = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};

    initial begin
        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #1;
        check("por_out", out, 8'h0F);
        check("por_divq", div_q, 4'h0);
        check("por_flip", flip, 8'h00);
        toggle = 8'hFF; set = 8'hF0;
        tick();
        tick();
        check("rst_ignores_inputs", out, 8'h0F);
        toggle = '0; set = '0;
        rst = 1'b0;

        // Plain T flip-flop on channel 0.
        toggle = 8'h01;
        tick(); check("t0_out1", out, 8'h0E); check("t0_flip1", flip, 8'h00);
        tick(); check("t0_out2", out, 8'h0F); check("t0_flip2", flip, 8'h01);
        tick(); check("t0_out3", out, 8'h0E); check("t0_flip3", flip, 8'h01);
        tick(); check("t0_out4", out, 8'h0F); check("t0_flip4", flip, 8'h01);
        toggle = '0;
        tick(); check("t0_out5", out, 8'h0F); check("t0_flip5", flip, 8'h01);
        tick(); check("t0_flip6", flip, 8'h00);

        // Divide by 3 on channel 1. The toggle in the load cycle is discarded.
        div_load = 1'b1; div_in = 4'd2; toggle = 8'h02;
        tick();
        check("ld2_divq", div_q, 4'd2);
        check("ld2_out", out, 8'h0F);
        div_load = 1'b0; toggle = '0;
        for (int k = 0; k < 6; k++) begin
            toggle = 8'h02;
            tick();
            check($sformatf("div3_out_req%0d", k + 1), out, exp_out033[k]);
            toggle = '0;
            tick();
            check($sformatf("div3_flip_req%0d", k + 1), flip, exp_flip033[k]);
        end

        // clr > set > toggle on channel 2, including count restart.
        toggle = 8'h04;
        tick(); check("c2_pre", out, 8'h0F);          // cnt2 = 1
        set = 8'h04; clr = 8'h04; toggle = 8'h04;
        tick(); check("c2_setclr_out", out, 8'h0B);
        set = '0; clr = '0; toggle = '0;
        tick(); check("c2_setclr_flip", flip, 8'h04);
        set = 8'h04; clr = 8'h04; toggle = 8'h04;
        tick(); check("c2_setclr_again", out, 8'h0B);
        set = '0; clr = '0; toggle = '0;
        tick(); check("c2_noflip", flip, 8'h00);
        toggle = 8'h04;
        tick(); check("c2_req1", out, 8'h0B);
        tick(); check("c2_req2", out, 8'h0B);
        tick(); check("c2_req3", out, 8'h0F);
        toggle = '0;
        // set on a channel already at 1 must not pulse flip.
        set = 8'h01;
        tick(); check("set_hi_out", out, 8'h0F);
        set = '0;
        tick(); check("set_hi_noflip", flip, 8'h00);
        set = 8'h80;
        tick(); check("set_lo_out", out, 8'h8F);
        set = '0;
        tick(); check("set_lo_flip", flip, 8'h80);
        clr = 8'h80;
        tick(); check("clr_out", out, 8'h0F);
        clr = '0;

        // Divide by 4 on channel 4 with freeze in the middle.
        div_load = 1'b1; div_in = 4'd3;
        tick(); check("ld3_divq", div_q, 4'd3);
        div_load = 1'b0;
        toggle = 8'h10;
        tick(); check("fz_req1", out, 8'h0F);
        tick(); check("fz_req2", out, 8'h0F);
        freeze = 1'b1; clr = 8'h01;
        tick(); check("fz_clr_works", out, 8'h0E);
        clr = '0;
        for (int k = 0; k < 4; k++) begin
            tick(); check($sformatf("fz_hold%0d", k), out, 8'h0E);
        end
        freeze = 1'b0;
        tick(); check("fz_req3", out, 8'h0E);
        tick(); check("fz_req4", out, 8'h1E);
        toggle = '0;

        // Asynchronous reset mid-count on channel 5.
        toggle = 8'h20;
        tick(); tick();
        check("mid_count", out, 8'h1E);
        toggle = '0;
        #3 rst = 1'b1;
        #1;
        check("async_out", out, 8'h0F);
        check("async_divq", div_q, 4'h0);
        check("async_flip", flip, 8'h00);
        #1 rst = 1'b0;
        tick(); check("post_rst_flip", flip, 8'h00);
        toggle = 8'h20;
        tick(); check("post_rst_req1", out, 8'h2F);
        toggle = '0;
        tick(); check("post_rst_flip2", flip, 8'h20);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
